// File: rtl/regfile_dump_reader.sv
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : Walks REGFILE through both read ports, two registers per fetch,
//            and streams (address, data) beats on a valid/ready interface.
// Options  : REGDUMP_CHECKSUM_EN adds an XOR checksum of all dumped data.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regfile_dump_reader #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] adressread,
  output logic [ADDR_W-1:0] adressread2,
  input  logic [DATA_W-1:0] dataout,
  input  logic [DATA_W-1:0] dataout2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
`ifdef REGDUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND0 = 3'd2,
    S_SEND1 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // One extra pointer bit keeps the compare against NREGS from wrapping.
  localparam logic [ADDR_W:0]   c_nregs  = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W:0]   c_one    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   c_two    = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   c_three  = (ADDR_W+1)'(3);
  localparam logic [ADDR_W-1:0] c_first2 = (NREGS == 1) ? '0 : ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_ptr;
  logic [DATA_W-1:0] r_buf1;

  logic [ADDR_W:0]   w_ptr1;
  logic [ADDR_W:0]   w_ptr2;
  logic [ADDR_W:0]   w_ptr3;

  assign w_ptr1 = r_ptr + c_one;
  assign w_ptr2 = r_ptr + c_two;
  assign w_ptr3 = r_ptr + c_three;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_buf1      <= '0;
      adressread  <= '0;
      adressread2 <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      if (out_valid && out_ready) begin
        checksum <= checksum ^ out_data;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_ptr       <= '0;
            busy        <= 1'b1;
            adressread  <= '0;
            adressread2 <= c_first2;
`ifdef REGDUMP_CHECKSUM_EN
            checksum    <= '0;
`endif
          end
        end
        // Read addresses were set on entry; the pair is snapshotted here.
        S_FETCH: begin
          out_valid <= 1'b1;
          out_addr  <= adressread;
          out_data  <= dataout;
          r_buf1    <= dataout2;
          r_state   <= S_SEND0;
        end
        S_SEND0: begin
          if (out_ready) begin
            if (w_ptr1 < c_nregs) begin
              out_addr <= adressread2;
              out_data <= r_buf1;
              r_state  <= S_SEND1;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_SEND1: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_ptr     <= w_ptr2;
            if (w_ptr2 < c_nregs) begin
              adressread  <= w_ptr2[ADDR_W-1:0];
              adressread2 <= (w_ptr3 == c_nregs) ? w_ptr2[ADDR_W-1:0] : w_ptr3[ADDR_W-1:0];
              r_state     <= S_FETCH;
            end else begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a 32-entry and a 5-entry instance, each with
// a combinational regfile model behind the read ports.
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  adressread, adressread2, out_addr;
  logic [31:0] dataout, dataout2, out_data;
  logic        out_valid, busy, done;
  logic [31:0] rf [0:31];

  logic        start5 = 1'b0;
  logic        ready5 = 1'b1;
  logic [2:0]  ra5, ra5b, addr5;
  logic [31:0] dout5, dout5b, data5;
  logic        valid5, busy5, done5;
  logic [31:0] rf5 [0:7];

`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] checksum, checksum5;
`endif

  int checks = 0;
  int errors = 0;
  int q_addr[$];
  int q_data[$];
  int first_e, done_e, done_pulses;
  logic [31:0] cs_done;

  always #5 clk = ~clk;

  assign dataout  = rf[adressread];
  assign dataout2 = rf[adressread2];
  assign dout5    = rf5[ra5];
  assign dout5b   = rf5[ra5b];

  regfile_dump_reader #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .adressread(adressread), .adressread2(adressread2),
    .dataout(dataout), .dataout2(dataout2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy),
`ifdef REGDUMP_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  regfile_dump_reader #(.NREGS(5), .ADDR_W(3), .DATA_W(32)) dut5 (
    .clk(clk), .rst(rst), .start(start5),
    .adressread(ra5), .adressread2(ra5b),
    .dataout(dout5), .dataout2(dout5b),
    .out_valid(valid5), .out_ready(ready5),
    .out_addr(addr5), .out_data(data5), .busy(busy5),
`ifdef REGDUMP_CHECKSUM_EN
    .checksum(checksum5),
`endif
    .done(done5)
  );

  typedef struct {
    logic rdy;
    logic v;
    int   a;
    int   d;
    int   ra;
    int   ra2;
    logic dn;
    logic bz;
  } vec_t;

  vec_t tbl [0:10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1 pattern; 2: overwrite r2 during
  // SEND1 of pair (2,3); 3: re-pulse start mid-dump, then rst after beat 7.
  task automatic dump32(input int mode);
    logic       prev_v, prev_r;
    logic [4:0] prev_a;
    logic [31:0] prev_d;
    q_addr.delete();
    q_data.delete();
    first_e = -1;
    done_e = -1;
    done_pulses = 0;
    prev_v = 1'b0;
    prev_r = 1'b1;
    prev_a = '0;
    prev_d = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e < 400; e++) begin
      out_ready = (mode == 1) ? ((e % 4 == 0) || (e % 4 == 3)) : 1'b1;
      if (mode == 2 && e == 5) rf[2] = 32'd8;
      start = (mode == 3 && e == 5);
      if (prev_v && !prev_r) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", out_addr, prev_a);
        chk("stall_data", out_data, prev_d);
      end
      if (out_valid && first_e < 0) first_e = e;
      if (out_valid && out_ready) begin
        q_addr.push_back(int'(out_addr));
        q_data.push_back(int'(out_data));
      end
      if (done) begin
        done_pulses++;
        if (done_e < 0) begin
          done_e = e;
`ifdef REGDUMP_CHECKSUM_EN
          cs_done = checksum;
`endif
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_a = out_addr;
      prev_d = out_data;
      if (mode == 3 && q_addr.size() == 7) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        break;
      end
      if (done_e >= 0 && e == done_e + 1) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (mode != 3) chk("dump_completed", done_e >= 0, 1);
  endtask

  task automatic check_seq(input string tag, input int n, input int reg2val);
    int exp_d;
    chk({tag, "_beats"}, q_addr.size(), n);
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      exp_d = (i == 2) ? reg2val : i * 3;
      chk($sformatf("%s_addr%0d", tag, i), q_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), q_data[i], exp_d);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    for (int i = 0; i < 8; i++) rf5[i] = 32'(i + 10);

    //          rdy v  a  d   ra ra2 dn bz
    tbl[0]  = '{1, 0, 0, 0,  0, 1,  0, 1};
    tbl[1]  = '{1, 1, 0, 10, 0, 1,  0, 1};
    tbl[2]  = '{1, 1, 1, 11, 0, 1,  0, 1};
    tbl[3]  = '{1, 0, 1, 11, 2, 3,  0, 1};
    tbl[4]  = '{0, 1, 2, 12, 2, 3,  0, 1};
    tbl[5]  = '{1, 1, 2, 12, 2, 3,  0, 1};
    tbl[6]  = '{1, 1, 3, 13, 2, 3,  0, 1};
    tbl[7]  = '{1, 0, 3, 13, 4, 4,  0, 1};
    tbl[8]  = '{1, 1, 4, 14, 4, 4,  0, 1};
    tbl[9]  = '{1, 0, 4, 14, 4, 4,  1, 1};
    tbl[10] = '{1, 0, 4, 14, 4, 4,  0, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ra", adressread, 0);
    chk("rst_ra2", adressread2, 0);
    chk("rst_valid5", valid5, 0);

    // NREGS=5 walk with one stall cycle
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    for (int e = 0; e < 11; e++) begin
      ready5 = tbl[e].rdy;
      chk($sformatf("n5_e%0d_valid", e), valid5, tbl[e].v);
      chk($sformatf("n5_e%0d_addr", e), addr5, tbl[e].a);
      chk($sformatf("n5_e%0d_data", e), data5, tbl[e].d);
      chk($sformatf("n5_e%0d_ra", e), ra5, tbl[e].ra);
      chk($sformatf("n5_e%0d_ra2", e), ra5b, tbl[e].ra2);
      chk($sformatf("n5_e%0d_done", e), done5, tbl[e].dn);
      chk($sformatf("n5_e%0d_busy", e), busy5, tbl[e].bz);
      @(posedge clk); #1;
    end
    ready5 = 1'b1;

    // Full dump, ready held high
    dump32(0);
    check_seq("full", 32, 6);
    chk("first_valid_edge", first_e, 1);
    chk("done_edge", done_e, 48);
    chk("done_pulses", done_pulses, 1);

    // Backpressure
    dump32(1);
    check_seq("bp", 32, 6);
    chk("bp_done_pulses", done_pulses, 1);

    // Ignored restart, then abort by rst
    dump32(3);
    check_seq("abort", 7, 6);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ra", adressread, 0);
    dump32(0);
    check_seq("restart", 32, 6);

    // Snapshot: write to r2 after its pair was buffered
    dump32(2);
    check_seq("snap_old", 32, 6);
    dump32(0);
    check_seq("snap_new", 32, 8);
    rf[2] = 32'd6;

`ifdef REGDUMP_CHECKSUM_EN
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd8;
    rf[2] = 32'd8;
    dump32(0);
    chk("checksum_cancel", cs_done, 0);
    rf[2] = 32'd5;
    dump32(0);
    chk("checksum_13", cs_done, 13);
    @(posedge clk); #1;
    chk("checksum_hold", checksum, 13);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
